lock_key_loader: RTL and testbench

Loads the 32-bit logic-locking key for the locked c432 netlist and drives its key inputs. A bit-serial stream with valid/ready handshake carries the key followed by one even-parity bit. The block assembles the key in a shadow register, checks parity, and commits it to the registered key outputs. Repeated parity failures permanently lock out the loader until reset.

---
 rtl/lock_key_loader_pkg.sv | 20 ++
 rtl/lock_key_loader_if.sv | 29 ++
 rtl/lock_key_loader_key_shift_reg.sv | 29 ++
 rtl/lock_key_loader.sv | 164 ++++++++++++++++
 tb/tb_lock_key_loader.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/lock_key_loader_pkg.sv
// Shared types and constants for the c432 key loader.
// State encoding, default sizes, counter width helper.
package lock_key_pkg;

  localparam int KEY_W_DEF    = 32;
  localparam int MAX_FAIL_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    CHECK,
    LOCKOUT
  } key_ld_state_e;

  function automatic int cntWidth(input int keyW);
    return $clog2(keyW + 1);
  endfunction

endpackage

// File: rtl/lock_key_loader_if.sv
// Serial key stream and key-output bundle.
// master drives the stream, slave is the loader.
interface lock_key_loader_if #(
  parameter int KEY_W = 32
);

  logic             load_start;
  logic             bit_valid;
  logic             bit_data;
  logic             bit_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             load_busy;
  logic             load_err;
  logic             locked_out;

  modport master (
    output load_start, bit_valid, bit_data,
    input  bit_ready, key_out, key_valid,
    input  load_busy, load_err, locked_out
  );

  modport slave (
    input  load_start, bit_valid, bit_data,
    output bit_ready, key_out, key_valid,
    output load_busy, load_err, locked_out
  );

endinterface

// File: rtl/lock_key_loader_key_shift_reg.sv
// Shadow register for the incoming key, LSB-first.
// Tracks running parity so the check only needs P.
module key_shift_reg #(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shiftEn,
  input  logic             serIn,
  output logic [KEY_W-1:0] shadow,
  output logic             parity
);

  // Shift right so the first bit lands in bit 0 after KEY_W shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      shadow <= '0;
      parity <= 1'b0;
    end else if (shiftEn) begin
      shadow <= {serIn, shadow[KEY_W-1:1]};
      parity <= parity ^ serIn;
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// Key loader for the locked c432: serial load,
// parity check, commit, and lockout on repeated failure.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input logic clk,
  input logic rst,
  lock_key_loader_if.slave bus
);

  localparam int CNT_W = cntWidth(KEY_W);

  key_ld_state_e state;
  key_ld_state_e stateNext;

  logic [CNT_W-1:0] bitCnt;
  logic [3:0]       failCnt;
  logic [3:0]       failInc;
  logic             pBit;
  logic [KEY_W-1:0] keyReg;
  logic             validReg;
  logic             errReg;

  logic [KEY_W-1:0] shadow;
  logic             shParity;

  logic clr;
  logic shiftEn;
  logic cntInc;
  logic pLoad;
  logic startLd;
  logic commit;
  logic fail;
  logic xfer;
  logic readyDec;

  assign readyDec = (state == SHIFT) || (state == PARITY);
  assign xfer     = bus.bit_valid & readyDec;
  assign failInc  = failCnt + 4'd1;

  key_shift_reg #(
    .KEY_W(KEY_W)
  ) uShift (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .shiftEn(shiftEn),
    .serIn  (bus.bit_data),
    .shadow (shadow),
    .parity (shParity)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and datapath controls.
  always_comb begin
    stateNext = state;
    clr       = 1'b0;
    shiftEn   = 1'b0;
    cntInc    = 1'b0;
    pLoad     = 1'b0;
    startLd   = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (bus.load_start) begin
          startLd   = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.load_start) begin
          clr     = 1'b1;
          startLd = 1'b1;
        end else if (xfer) begin
          shiftEn = 1'b1;
          cntInc  = 1'b1;
          if (bitCnt == CNT_W'(KEY_W - 1))
            stateNext = PARITY;
        end
      end
      PARITY: begin
        if (bus.load_start) begin
          clr       = 1'b1;
          startLd   = 1'b1;
          stateNext = SHIFT;
        end else if (xfer) begin
          pLoad     = 1'b1;
          stateNext = CHECK;
        end
      end
      CHECK: begin
        if ((shParity ^ pBit) == 1'b0) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end else begin
          fail = 1'b1;
          if (failInc == 4'(MAX_FAIL))
            stateNext = LOCKOUT;
          else
            stateNext = IDLE;
        end
      end
      LOCKOUT: stateNext = LOCKOUT;
      default: stateNext = IDLE;
    endcase
  end

  // Bit counter and captured parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt <= '0;
      pBit   <= 1'b0;
    end else begin
      if (clr)         bitCnt <= '0;
      else if (cntInc) bitCnt <= bitCnt + 1'b1;
      if (clr)        pBit <= 1'b0;
      else if (pLoad) pBit <= bus.bit_data;
    end
  end

  // Consecutive failure count; only a commit clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         failCnt <= '0;
    else if (commit) failCnt <= '0;
    else if (fail)   failCnt <= failInc;
  end

  // Committed key, valid flag and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyReg   <= '0;
      validReg <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      errReg <= fail;
      if (startLd || fail) begin
        keyReg   <= '0;
        validReg <= 1'b0;
      end else if (commit) begin
        keyReg   <= shadow;
        validReg <= 1'b1;
      end
    end
  end

  assign bus.bit_ready  = readyDec;
  assign bus.key_out    = keyReg;
  assign bus.key_valid  = validReg;
  assign bus.load_err   = errReg;
  assign bus.load_busy  = (state == SHIFT) || (state == PARITY)
                       || (state == CHECK);
  assign bus.locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: table of loads
// plus lockout, restart and mid-load reset sequences.
module tb_lock_key_loader;

  localparam int KW = 32;

  typedef struct {
    logic [31:0] key;
    logic        par;
    int          gap;
    logic        expValid;
    logic [31:0] expKey;
    int          expErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;
  int errSeen = 0;
  int edges = 0;

  vec_t vecs[8];

  lock_key_loader_if #(.KEY_W(KW)) bus ();

  lock_key_loader #(
    .KEY_W   (KW),
    .MAX_FAIL(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
    if (bus.load_err) errSeen++;
  endtask

  task automatic doLoad(input logic [31:0] k, input logic p,
                        input int gap, input logic expBusy);
    logic [31:0] kv;
    int n;
    kv = k;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.bit_valid  = 1'b0;
    edges   = 0;
    errSeen = 0;
    chk("startBusy", bus.load_busy, expBusy);
    chk("startReady", bus.bit_ready, expBusy);
    chk("startValid", bus.key_valid, 0);
    chk("startKey", bus.key_out, 0);
    for (int i = 0; i <= KW; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) tick();
      bus.bit_valid = 1'b1;
      bus.bit_data  = (i < KW) ? kv[i] : p;
      tick();
      bus.bit_valid = 1'b0;
    end
    n = 0;
    while (bus.load_busy && n < 8) begin
      tick();
      n++;
    end
    chk("doneTimeout", bus.load_busy, 0);
  endtask

  task automatic chkReset(input string nm);
    chk({nm, "Busy"}, bus.load_busy, 0);
    chk({nm, "Ready"}, bus.bit_ready, 0);
    chk({nm, "Valid"}, bus.key_valid, 0);
    chk({nm, "Key"}, bus.key_out, 0);
    chk({nm, "Err"}, bus.load_err, 0);
    chk({nm, "Lock"}, bus.locked_out, 0);
  endtask

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, 1'b0, 0, 1'b1, 32'hA5A5_0F0F, 0};
    vecs[1] = '{32'hA5A5_0F0F, 1'b1, 0, 1'b0, 32'h0, 1};
    vecs[2] = '{32'hA5A5_0F0F, 1'b0, 0, 1'b1, 32'hA5A5_0F0F, 0};
    vecs[3] = '{32'h0000_0001, 1'b1, 0, 1'b1, 32'h0000_0001, 0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 0};
    vecs[5] = '{32'h8000_0000, 1'b0, 0, 1'b0, 32'h0, 1};
    vecs[6] = '{32'h8000_0000, 1'b1, 0, 1'b1, 32'h8000_0000, 0};
    vecs[7] = '{32'hA5A5_0F0F, 1'b0, 5, 1'b1, 32'hA5A5_0F0F, 0};

    bus.load_start = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_data   = 1'b0;
    tick();
    tick();
    chkReset("rst");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      doLoad(vecs[v].key, vecs[v].par, vecs[v].gap, 1'b1);
      chk($sformatf("v%0dValid", v), bus.key_valid, vecs[v].expValid);
      chk($sformatf("v%0dKey", v), bus.key_out, vecs[v].expKey);
      chk($sformatf("v%0dErr", v), errSeen, vecs[v].expErr);
      chk($sformatf("v%0dLock", v), bus.locked_out, 0);
      if (vecs[v].gap == 0)
        chk($sformatf("v%0dLatency", v), edges, KW + 2);
    end

    for (int i = 0; i < 3; i++) begin
      doLoad(32'hA5A5_0F0F, 1'b1, 0, 1'b1);
      chk($sformatf("bad%0dErr", i), errSeen, 1);
      chk($sformatf("bad%0dLock", i), bus.locked_out, (i == 2));
      chk($sformatf("bad%0dValid", i), bus.key_valid, 0);
    end
    chk("lockBusy", bus.load_busy, 0);
    chk("lockKey", bus.key_out, 0);

    doLoad(32'hA5A5_0F0F, 1'b0, 0, 1'b0);
    chk("lockedLock", bus.locked_out, 1);
    chk("lockedValid", bus.key_valid, 0);
    chk("lockedReady", bus.bit_ready, 0);
    chk("lockedErr", errSeen, 0);

    rst = 1'b1;
    #1;
    chkReset("unlock");
    tick();
    rst = 1'b0;
    tick();
    doLoad(32'hA5A5_0F0F, 1'b0, 0, 1'b1);
    chk("afterRstValid", bus.key_valid, 1);
    chk("afterRstKey", bus.key_out, 32'hA5A5_0F0F);

    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_data  = 1'b1;
      tick();
    end
    bus.bit_data = 1'b1;
    doLoad(32'h0000_0001, 1'b1, 0, 1'b1);
    chk("restartValid", bus.key_valid, 1);
    chk("restartKey", bus.key_out, 32'h0000_0001);
    chk("restartErr", errSeen, 0);
    chk("restartLatency", edges, KW + 2);

    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_data  = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    chk("midBusy", bus.load_busy, 1);
    rst = 1'b1;
    #1;
    chkReset("midRst");
    tick();
    rst = 1'b0;
    tick();
    doLoad(32'hA5A5_0F0F, 1'b0, 0, 1'b1);
    chk("finalValid", bus.key_valid, 1);
    chk("finalKey", bus.key_out, 32'hA5A5_0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
